// File: rtl/mac_vec_engine.sv
// Vector multiply-accumulate engine: LANES-wide signed dot product plus
// cascade term per beat, accumulated into framed results.
module mac_vec_engine #(
    parameter int A_W   = 25,
    parameter int B_W   = 18,
    parameter int P_W   = 48,
    parameter int LANES = 4,
    parameter bit SAT   = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 sclr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic                 mode,
    input  logic [LANES*A_W-1:0] a,
    input  logic [LANES*B_W-1:0] b,
    input  logic [P_W-1:0]       pcin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P_W-1:0]       p,
    output logic [P_W-1:0]       pcout,
    output logic                 ovf,
    output logic [CNT_W-1:0]     out_beats
);

    localparam int M_W = A_W + B_W;
    localparam logic [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
    localparam logic [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};

    logic en;

    logic                 s1_v;
    logic                 s1_last;
    logic [LANES*A_W-1:0] s1_a;
    logic [LANES*B_W-1:0] s1_b;
    logic [P_W-1:0]       s1_pcin;

    logic signed [M_W-1:0] prod [LANES];
    logic signed [M_W-1:0] s2_prod [LANES];
    logic                  s2_v;
    logic                  s2_last;
    logic [P_W-1:0]        s2_pcin;

    logic signed [P_W-1:0] tree;
    logic                  s3_v;
    logic                  s3_last;
    logic [P_W-1:0]        s3_sum;

    logic [P_W-1:0]   acc;
    logic             acc_ovf;
    logic [CNT_W-1:0] cnt;

    logic [P_W:0]     wide;
    logic             nof;
    logic [P_W-1:0]   nacc;
    logic             novf;
    logic [CNT_W-1:0] ncnt;
    logic             fire_last;

    // A held result that is not being taken stalls the whole pipe.
    assign en        = ce & ~(out_valid & ~out_ready);
    assign in_ready  = en;
    assign pcout     = p;
    assign fire_last = s3_v & s3_last;

    // Stage 1: capture the accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_pcin <= '0;
        end else if (sclr) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_pcin <= '0;
        end else if (en) begin
            s1_v    <= in_valid;
            s1_last <= in_last | mode;
            s1_a    <= a;
            s1_b    <= b;
            s1_pcin <= pcin;
        end
    end

    // Full-precision signed lane products.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i] = M_W'($signed(s1_a[i*A_W +: A_W]))
                    * M_W'($signed(s1_b[i*B_W +: B_W]));
        end
    end

    // Stage 2: register the products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
            s2_pcin <= '0;
            for (int i = 0; i < LANES; i++) s2_prod[i] <= '0;
        end else if (sclr) begin
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
            s2_pcin <= '0;
            for (int i = 0; i < LANES; i++) s2_prod[i] <= '0;
        end else if (en) begin
            s2_v    <= s1_v;
            s2_last <= s1_last;
            s2_pcin <= s1_pcin;
            for (int i = 0; i < LANES; i++) s2_prod[i] <= prod[i];
        end
    end

    // Sum of sign-extended products plus cascade, wrapping in P_W bits.
    always_comb begin
        tree = $signed(s2_pcin);
        for (int i = 0; i < LANES; i++) begin
            tree = tree + P_W'(s2_prod[i]);
        end
    end

    // Stage 3: register the beat sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v    <= 1'b0;
            s3_last <= 1'b0;
            s3_sum  <= '0;
        end else if (sclr) begin
            s3_v    <= 1'b0;
            s3_last <= 1'b0;
            s3_sum  <= '0;
        end else if (en) begin
            s3_v    <= s2_v;
            s3_last <= s2_last;
            s3_sum  <= tree;
        end
    end

    // Next accumulator value; an empty frame holds acc=0 so no special case.
    always_comb begin
        wide = {acc[P_W-1], acc} + {s3_sum[P_W-1], s3_sum};
        nof  = wide[P_W] ^ wide[P_W-1];
        nacc = wide[P_W-1:0];
        if (SAT && nof) nacc = wide[P_W] ? P_MIN : P_MAX;
        novf = acc_ovf | nof;
        ncnt = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    // Stage 4: frame accumulator, re-armed after each last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
            cnt     <= '0;
        end else if (sclr) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
            cnt     <= '0;
        end else if (en && s3_v) begin
            if (s3_last) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
                cnt     <= '0;
            end else begin
                acc     <= nacc;
                acc_ovf <= novf;
                cnt     <= ncnt;
            end
        end
    end

    // Result register: loaded on a last beat, dropped after handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            p         <= '0;
            ovf       <= 1'b0;
            out_beats <= '0;
        end else if (sclr) begin
            out_valid <= 1'b0;
            p         <= '0;
            ovf       <= 1'b0;
            out_beats <= '0;
        end else if (en) begin
            out_valid <= fire_last;
            if (fire_last) begin
                p         <= nacc;
                ovf       <= novf;
                out_beats <= ncnt;
            end
        end
    end

endmodule

// File: tb/tb_mac_vec_engine.sv
// Bench for mac_vec_engine: saturating and wrapping instances share
// stimulus and are checked against a frame-level arithmetic model.
module tb_mac_vec_engine;

    localparam int A_W   = 25;
    localparam int B_W   = 18;
    localparam int P_W   = 48;
    localparam int LANES = 4;
    localparam int CNT_W = 16;
    localparam longint PMAX = (longint'(1) <<< 47) - 1;
    localparam longint PMIN = -(longint'(1) <<< 47);

    logic clk = 1'b0;
    logic rst_n, ce, sclr, in_valid, in_last, mode, out_ready;
    logic [LANES*A_W-1:0] a;
    logic [LANES*B_W-1:0] b;
    logic [P_W-1:0]       pcin;

    logic rdy_s, ov_s, ovf_s, rdy_w, ov_w, ovf_w;
    logic [P_W-1:0]   p_s, pc_s, p_w, pc_w;
    logic [CNT_W-1:0] bt_s, bt_w;

    mac_vec_engine #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .LANES(LANES),
                     .SAT(1'b1), .CNT_W(CNT_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr),
        .in_valid(in_valid), .in_ready(rdy_s), .in_last(in_last),
        .mode(mode), .a(a), .b(b), .pcin(pcin),
        .out_valid(ov_s), .out_ready(out_ready), .p(p_s),
        .pcout(pc_s), .ovf(ovf_s), .out_beats(bt_s));

    mac_vec_engine #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .LANES(LANES),
                     .SAT(1'b0), .CNT_W(CNT_W)) dut_w (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr),
        .in_valid(in_valid), .in_ready(rdy_w), .in_last(in_last),
        .mode(mode), .a(a), .b(b), .pcin(pcin),
        .out_valid(ov_w), .out_ready(out_ready), .p(p_w),
        .pcout(pc_w), .ovf(ovf_w), .out_beats(bt_w));

    always #5 clk = ~clk;

    typedef struct {
        longint ps;
        bit     os;
        longint pw;
        bit     ow;
        int     n;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     hs_cnt = 0;
    int     acc_cyc = 0;
    longint m_s = 0;
    longint m_w = 0;
    bit     m_os = 0;
    bit     m_ow = 0;
    int     m_n = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] u48(input longint v);
        return {16'h0, v[47:0]};
    endfunction

    function automatic longint sx48(input longint v);
        logic [47:0] t;
        t = v[47:0];
        return longint'($signed(t));
    endfunction

    // Frame model: exact integer dot product, then the accumulate rules.
    always @(posedge clk) begin
        longint tot;
        longint t;
        exp_t   e;
        cyc++;
        if (!rst_n || sclr) begin
            q.delete();
            m_s = 0; m_w = 0; m_os = 0; m_ow = 0; m_n = 0;
        end else begin
            if (ov_s && out_ready && ce) begin
                hs_cnt++;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && rdy_s) begin
                acc_cyc = cyc;
                tot = longint'($signed(pcin));
                for (int l = 0; l < LANES; l++)
                    tot += longint'($signed(a[l*A_W +: A_W]))
                         * longint'($signed(b[l*B_W +: B_W]));
                tot = sx48(tot);
                t = m_s + tot;
                if (t > PMAX) begin t = PMAX; m_os = 1; end
                else if (t < PMIN) begin t = PMIN; m_os = 1; end
                m_s = t;
                t = m_w + tot;
                if (t > PMAX || t < PMIN) m_ow = 1;
                m_w = sx48(t);
                if (m_n < 65535) m_n++;
                if (in_last || mode) begin
                    e.ps = m_s; e.os = m_os; e.pw = m_w;
                    e.ow = m_ow; e.n = m_n;
                    q.push_back(e);
                    m_s = 0; m_w = 0; m_os = 0; m_ow = 0; m_n = 0;
                end
            end
        end
    end

    // Every shown result must be the oldest outstanding model result.
    always @(negedge clk) begin
        if (rst_n && (ov_s || ov_w)) begin
            if (q.size() == 0) begin
                chk("spurious_out", {63'd0, ov_s | ov_w}, 64'd0);
            end else begin
                chk("cmp_valid_s", {63'd0, ov_s}, 64'd1);
                chk("cmp_valid_w", {63'd0, ov_w}, 64'd1);
                chk("cmp_p_s", {16'h0, p_s}, u48(q[0].ps));
                chk("cmp_pc_s", {16'h0, pc_s}, u48(q[0].ps));
                chk("cmp_ovf_s", {63'd0, ovf_s}, {63'd0, q[0].os});
                chk("cmp_p_w", {16'h0, p_w}, u48(q[0].pw));
                chk("cmp_pc_w", {16'h0, pc_w}, u48(q[0].pw));
                chk("cmp_ovf_w", {63'd0, ovf_w}, {63'd0, q[0].ow});
                chk("cmp_beats_s", {48'h0, bt_s}, 64'(q[0].n));
                chk("cmp_beats_w", {48'h0, bt_w}, 64'(q[0].n));
            end
        end
    end

    task automatic beat(input int a0, input int a1, input int a2,
                        input int a3, input int b0, input int b1,
                        input int b2, input int b3, input int pc,
                        input logic last);
        bit ok;
        int n;
        a = {A_W'(a3), A_W'(a2), A_W'(a1), A_W'(a0)};
        b = {B_W'(b3), B_W'(b2), B_W'(b1), B_W'(b0)};
        pcin = P_W'(pc);
        in_last = last;
        in_valid = 1'b1;
        ok = 0;
        n = 0;
        while (!ok && n < 100) begin
            #1 ok = rdy_s;
            @(negedge clk);
            n++;
        end
        chk("beat_accept", {63'd0, ok}, 64'd1);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (!ov_s && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("out_timeout", {63'd0, ov_s}, 64'd1);
        lat = cyc - acc_cyc;
    endtask

    task automatic single_beat();
        beat(2, 4, 0, 1, 3, 5, 9, 7, 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t0, t1;
        rst_n = 1'b0; ce = 1'b1; sclr = 1'b0; in_valid = 1'b0;
        in_last = 1'b0; mode = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; pcin = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, ov_s | ov_w}, 64'd0);
        chk("rst_p", {16'h0, p_s | p_w}, 64'd0);
        chk("rst_pcout", {16'h0, pc_s | pc_w}, 64'd0);
        chk("rst_ovf", {63'd0, ovf_s | ovf_w}, 64'd0);
        chk("rst_beats", {48'h0, bt_s | bt_w}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        single_beat();
        wait_out(lat);
        chk("t1_lat", 64'(lat), 64'd3);
        chk("t1_p", {16'h0, p_s}, 64'd33);
        chk("t1_beats", {48'h0, bt_s}, 64'd1);
        chk("t1_ovf", {63'd0, ovf_s}, 64'd0);
        @(negedge clk);
        chk("t1_one_pulse", {63'd0, ov_s}, 64'd0);

        for (int f = 0; f < 2; f++) begin
            t0 = hs_cnt;
            beat(-1, 2, 0, 0, 7, 3, 0, 0, 0, 1'b0);
            t1 = acc_cyc;
            beat(16, 0, 0, 0, 'h20002, 0, 0, 0, 0, 1'b0);
            if (f == 1) begin
                ce = 1'b0;
                repeat (5) @(negedge clk);
                chk("fz_ready_low", {63'd0, rdy_s}, 64'd0);
                ce = 1'b1;
            end
            beat(8, 0, 0, 0, 2, 0, 0, 0, 1, 1'b1);
            wait_out(lat);
            chk("t2_lat", 64'(cyc - t1), (f == 1) ? 64'd10 : 64'd5);
            chk("t2_p", {16'h0, p_s}, 64'hFFFF_FFE0_0030);
            chk("t2_beats", {48'h0, bt_s}, 64'd3);
            repeat (3) @(negedge clk);
            chk("t2_pulses", 64'(hs_cnt - t0), 64'd1);
        end

        mode = 1'b1;
        out_ready = 1'b0;
        t0 = hs_cnt;
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    beat(k, 0, 0, 0, 10, 0, 0, 0, k, 1'b0);
            end
            begin
                int l2;
                wait_out(l2);
                chk("bp_first", {16'h0, p_s}, 64'd11);
                chk("bp_ready_low", {63'd0, rdy_s}, 64'd0);
                repeat (4) @(negedge clk);
                chk("bp_hold_p", {16'h0, p_s}, 64'd11);
                chk("bp_hold_v", {63'd0, ov_s}, 64'd1);
                chk("bp_no_hs", 64'(hs_cnt - t0), 64'd0);
                out_ready = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        chk("bp_drained", 64'(hs_cnt - t0), 64'd5);
        mode = 1'b0;

        for (int k = 0; k < 17; k++)
            beat('hFFFFFF, 'hFFFFFF, 'hFFFFFF, 'hFFFFFF,
                 'h1FFFF, 'h1FFFF, 'h1FFFF, 'h1FFFF, 0, k == 16);
        wait_out(lat);
        chk("sat_p", {16'h0, p_s}, 64'h7FFF_FFFF_FFFF);
        chk("sat_ovf", {63'd0, ovf_s}, 64'd1);
        chk("wrap_p", {16'h0, p_w}, 64'h87FF_BB78_0044);
        chk("wrap_ovf", {63'd0, ovf_w}, 64'd1);
        chk("sat_beats", {48'h0, bt_s}, 64'd17);
        for (int k = 0; k < 16; k++)
            beat('hFFFFFF, 'hFFFFFF, 'hFFFFFF, 'hFFFFFF,
                 'h1FFFF, 'h1FFFF, 'h1FFFF, 'h1FFFF, 0, k == 15);
        wait_out(lat);
        chk("n16_p_s", {16'h0, p_s}, 64'h7FFF_BF80_0040);
        chk("n16_p_w", {16'h0, p_w}, 64'h7FFF_BF80_0040);
        chk("n16_ovf", {63'd0, ovf_s | ovf_w}, 64'd0);
        for (int k = 0; k < 17; k++)
            beat(-16777216, -16777216, -16777216, -16777216,
                 'h1FFFF, 'h1FFFF, 'h1FFFF, 'h1FFFF, 0, k == 16);
        wait_out(lat);
        chk("neg_sat_p", {16'h0, p_s}, 64'h8000_0000_0000);
        chk("neg_sat_ovf", {63'd0, ovf_s}, 64'd1);
        repeat (2) @(negedge clk);

        for (int r = 0; r < 2; r++) begin
            t0 = hs_cnt;
            beat(-1, 2, 0, 0, 7, 3, 0, 0, 0, 1'b0);
            beat(16, 0, 0, 0, 'h20002, 0, 0, 0, 0, 1'b0);
            if (r == 0) sclr = 1'b1;
            else rst_n = 1'b0;
            @(negedge clk);
            sclr = 1'b0;
            rst_n = 1'b1;
            @(negedge clk);
            chk("clr_idle", {63'd0, ov_s}, 64'd0);
            single_beat();
            wait_out(lat);
            chk("clr_lat", 64'(lat), 64'd3);
            chk("clr_p", {16'h0, p_s}, 64'd33);
            chk("clr_beats", {48'h0, bt_s}, 64'd1);
            repeat (3) @(negedge clk);
            chk("clr_pulses", 64'(hs_cnt - t0), 64'd1);
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
